// File: rtl/comm_pkg.sv
// Shared constants, state encoding and byte-count helpers for the command engine.
package comm_pkg;

  localparam logic [7:0] OP_READ_EN   = 8'h01;
  localparam logic [7:0] OP_READ_MAP  = 8'h02;
  localparam logic [7:0] OP_WRITE_EN  = 8'h03;
  localparam logic [7:0] OP_WRITE_MAP = 8'h04;
  localparam logic [7:0] OP_READ_IN   = 8'h05;
  localparam logic [7:0] OP_WRITE_ONE = 8'h06;

  localparam logic [7:0] ST_ACK        = 8'hA0;
  localparam logic [7:0] ST_NAK_OPCODE = 8'hE1;
  localparam logic [7:0] ST_NAK_CHAN   = 8'hE2;
  localparam logic [7:0] ST_NAK_CSUM   = 8'hE3;
  localparam logic [7:0] ST_NAK_TMO    = 8'hE4;

  typedef enum logic [2:0] {
    S_IDLE, S_RX_PAYLOAD, S_RX_CSUM, S_EXEC, S_TX
  } state_t;

  // max(1, clog2(inputs)), written as a bounded loop so it folds at elaboration
  function automatic int sel_width(input int inputs);
    int w = 1;
    for (int i = 1; i <= 8; i++)
      if ((1 << i) < inputs) w = i + 1;
    return w;
  endfunction

  function automatic int byte_cnt(input int bits);
    return (bits + 7) / 8;
  endfunction

  function automatic int map_bytes(input int outputs, input int inputs);
    return byte_cnt(sel_width(inputs) * outputs);
  endfunction

  function automatic int en_bytes(input int outputs);
    return byte_cnt(outputs);
  endfunction

  function automatic int in_bytes(input int inputs);
    return byte_cnt(inputs);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/comm_ctrl_if.sv
// Byte-stream link between the uart rx/tx byte ports and the command engine.
interface comm_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  // master: the uart side, slave: the command engine
  modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data);
  modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data);
endinterface

// File: rtl/comm_resp_tx.sv
// Response serialiser: status byte, DATA bytes LSB first, then XOR of all sent bytes.
module comm_resp_tx #(
  parameter int DATA_B = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        status,
  input  logic [DATA_B*8-1:0] data,
  input  logic [7:0]        nbytes,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              done
);

  logic [DATA_B*8-1:0] shreg;
  logic [7:0]          left;
  logic [7:0]          csum;
  logic                last;
  logic                xfer;

  assign xfer = tx_valid && tx_ready;
  // done fires in the cycle the checksum byte is accepted
  assign done = xfer && last;

  // load on start, advance one byte per accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      shreg    <= '0;
      left     <= 8'd0;
      csum     <= 8'h00;
      last     <= 1'b0;
    end else if (start) begin
      tx_valid <= 1'b1;
      tx_data  <= status;
      csum     <= status;
      shreg    <= data;
      left     <= nbytes;
      last     <= 1'b0;
    end else if (xfer) begin
      if (last) begin
        tx_valid <= 1'b0;
        last     <= 1'b0;
      end else if (left != 8'd0) begin
        tx_data <= shreg[7:0];
        csum    <= csum ^ shreg[7:0];
        shreg   <= shreg >> 8;
        left    <= left - 8'd1;
      end else begin
        tx_data <= csum;
        last    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/comm_ctrl.sv
// Framed byte command engine: parses opcode/payload/csum, owns selector map and enables.
module comm_ctrl
  import comm_pkg::*;
#(
  parameter int OUTPUT_COUNT   = 16,
  parameter int INPUT_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int SEL_W         = sel_width(INPUT_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  comm_ctrl_if.slave                    bus,
  input  logic [INPUT_COUNT-1:0]        in_pins,
  output logic [SEL_W*OUTPUT_COUNT-1:0] selectors,
  output logic [OUTPUT_COUNT-1:0]       enabled_out,
  output logic                          err_overrun
);

  localparam int MAP_W = SEL_W * OUTPUT_COUNT;
  localparam int MAP_B = map_bytes(OUTPUT_COUNT, INPUT_COUNT);
  localparam int EN_B  = en_bytes(OUTPUT_COUNT);
  localparam int IN_B  = in_bytes(INPUT_COUNT);
  localparam int SHD_B = max3(MAP_B, EN_B, 3);
  localparam int DAT_B = max3(MAP_B, EN_B, IN_B);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 2);

  state_t                  state, state_n;
  logic [7:0]              opcode, plen, pcnt, xacc;
  logic [SHD_B-1:0][7:0]   shadow;
  logic [SHD_B*8-1:0]      shadow_flat;
  logic [TMO_W-1:0]        tmo_cnt;
  logic                    tmo_hit;
  logic [MAP_W-1:0]        sel_q;
  logic [OUTPUT_COUNT-1:0] en_q;
  logic [INPUT_COUNT-1:0]  in_s1, in_s2;
  logic                    op_known;
  logic [7:0]              op_len;
  logic                    ch_ok;
  logic                    rsp_start, rsp_done;
  logic [7:0]              rsp_status, rsp_len;
  logic [DAT_B*8-1:0]      rsp_data;

  assign shadow_flat = shadow;
  assign selectors   = sel_q;
  assign enabled_out = en_q;
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign ch_ok       = (shadow[0] < 8'(OUTPUT_COUNT));

  // opcode decode of the incoming byte (only meaningful in IDLE)
  always_comb begin
    op_known = 1'b1;
    op_len   = 8'd0;
    case (bus.rx_data)
      OP_READ_EN, OP_READ_MAP, OP_READ_IN: op_len = 8'd0;
      OP_WRITE_EN:  op_len = 8'(EN_B);
      OP_WRITE_MAP: op_len = 8'(MAP_B);
      OP_WRITE_ONE: op_len = 8'd3;
      default:      op_known = 1'b0;
    endcase
  end

  // readback vector, zero padded; sampled by the serialiser when EXEC starts it
  always_comb begin
    rsp_data = '0;
    case (opcode)
      OP_READ_EN:  rsp_data[OUTPUT_COUNT-1:0] = en_q;
      OP_READ_MAP: rsp_data[MAP_W-1:0]        = sel_q;
      OP_READ_IN:  rsp_data[INPUT_COUNT-1:0]  = in_s2;
      default: ;
    endcase
  end

  // next state and response request
  always_comb begin
    state_n    = state;
    rsp_start  = 1'b0;
    rsp_status = 8'h00;
    rsp_len    = 8'd0;
    case (state)
      S_IDLE: if (bus.rx_valid) begin
        if (!op_known) begin
          rsp_start  = 1'b1;
          rsp_status = ST_NAK_OPCODE;
          state_n    = S_TX;
        end else if (op_len == 8'd0) state_n = S_RX_CSUM;
        else                         state_n = S_RX_PAYLOAD;
      end
      S_RX_PAYLOAD: begin
        if (bus.rx_valid) begin
          if (pcnt == plen - 8'd1) state_n = S_RX_CSUM;
        end else if (tmo_hit) begin
          rsp_start  = 1'b1;
          rsp_status = ST_NAK_TMO;
          state_n    = S_TX;
        end
      end
      S_RX_CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == xacc) state_n = S_EXEC;
          else begin
            rsp_start  = 1'b1;
            rsp_status = ST_NAK_CSUM;
            state_n    = S_TX;
          end
        end else if (tmo_hit) begin
          rsp_start  = 1'b1;
          rsp_status = ST_NAK_TMO;
          state_n    = S_TX;
        end
      end
      S_EXEC: begin
        rsp_start  = 1'b1;
        rsp_status = ST_ACK | opcode;
        state_n    = S_TX;
        case (opcode)
          OP_READ_EN:   rsp_len = 8'(EN_B);
          OP_READ_MAP:  rsp_len = 8'(MAP_B);
          OP_READ_IN:   rsp_len = 8'(IN_B);
          OP_WRITE_ONE: if (!ch_ok) rsp_status = ST_NAK_CHAN;
          default: ;
        endcase
      end
      S_TX: if (rsp_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // frame capture: opcode, payload shadow, running XOR and inter-byte timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode  <= 8'h00;
      plen    <= 8'd0;
      pcnt    <= 8'd0;
      xacc    <= 8'h00;
      shadow  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == S_IDLE && bus.rx_valid) begin
        opcode  <= bus.rx_data;
        plen    <= op_len;
        pcnt    <= 8'd0;
        xacc    <= bus.rx_data;
        tmo_cnt <= '0;
      end
      if (state == S_RX_PAYLOAD || state == S_RX_CSUM)
        tmo_cnt <= bus.rx_valid ? '0 : tmo_cnt + 1'b1;
      if (state == S_RX_PAYLOAD && bus.rx_valid) begin
        for (int i = 0; i < SHD_B; i++)
          if (pcnt == 8'(i)) shadow[i] <= bus.rx_data;
        pcnt <= pcnt + 8'd1;
        xacc <= xacc ^ bus.rx_data;
      end
    end
  end

  // atomic commit of the validated shadow; padding bits fall off the slices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      en_q  <= '0;
    end else if (state == S_EXEC) begin
      case (opcode)
        OP_WRITE_EN:  en_q  <= shadow_flat[OUTPUT_COUNT-1:0];
        OP_WRITE_MAP: sel_q <= shadow_flat[MAP_W-1:0];
        OP_WRITE_ONE:
          for (int c = 0; c < OUTPUT_COUNT; c++)
            if (shadow[0] == 8'(c)) begin
              sel_q[c*SEL_W +: SEL_W] <= shadow[1][SEL_W-1:0];
              en_q[c]                 <= shadow[2][0];
            end
        default: ;
      endcase
    end
  end

  // 2-flop input synchroniser and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1       <= '0;
      in_s2       <= '0;
      err_overrun <= 1'b0;
    end else begin
      in_s1 <= in_pins;
      in_s2 <= in_s1;
      if (state == S_TX && bus.rx_valid) err_overrun <= 1'b1;
    end
  end

  comm_resp_tx #(.DATA_B(DAT_B)) u_resp (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (rsp_start),
    .status   (rsp_status),
    .data     (rsp_data),
    .nbytes   (rsp_len),
    .tx_ready (bus.tx_ready),
    .tx_valid (bus.tx_valid),
    .tx_data  (bus.tx_data),
    .done     (rsp_done)
  );

endmodule

// File: tb/tb_comm_ctrl.sv
// Bench for comm_ctrl: frame table with scoreboarded responses plus corner sequences.
module tb_comm_ctrl;

  localparam int OC  = 16;
  localparam int IC  = 4;
  localparam int TMO = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IC-1:0]   in_pins;
  logic [2*OC-1:0] selectors;
  logic [OC-1:0]   enabled_out;
  logic            err_overrun;

  comm_ctrl_if bus();

  comm_ctrl #(.OUTPUT_COUNT(OC), .INPUT_COUNT(IC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .in_pins     (in_pins),
    .selectors   (selectors),
    .enabled_out (enabled_out),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] fr;   // frame bytes, first byte in the most significant used position
    int          fn;
    logic [63:0] rs;   // response bytes without csum, same ordering
    int          rn;
    logic [15:0] en;   // enabled_out after the frame
    logic [31:0] sel;  // selectors after the frame
  } vec_t;

  vec_t       tv[13];
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // one clock: check any transfer seen at negedge, return 1 time unit after posedge
  task automatic tick();
    @(negedge clk);
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL tx_unexpected got %h expected nothing", bus.tx_data);
      end else begin
        chk("tx_byte", 32'(bus.tx_data), 32'(sb.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic push_resp(input logic [63:0] rs, input int rn);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    for (int i = 0; i < rn; i++) begin
      b = rs[(rn-1-i)*8 +: 8];
      sb.push_back(b);
      cs ^= b;
    end
    sb.push_back(cs);
  endtask

  task automatic send_frame(input logic [63:0] fr, input int fn);
    for (int i = 0; i < fn; i++) send(fr[(fn-1-i)*8 +: 8]);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s response missing, got %0d bytes pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic early;
    logic stable;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    in_pins      = 4'b1010;

    tv[0]  = '{64'h03341225,     4, 64'hA3,         1, 16'h1234, 32'h00000000};
    tv[1]  = '{64'h0101,         2, 64'hA13412,     3, 16'h1234, 32'h00000000};
    tv[2]  = '{64'h03FFFF00,     4, 64'hE3,         1, 16'h1234, 32'h00000000};
    tv[3]  = '{64'h09,           1, 64'hE1,         1, 16'h1234, 32'h00000000};
    tv[4]  = '{64'h0605030101,   5, 64'hA6,         1, 16'h1234, 32'h00000C00};
    tv[5]  = '{64'h0603020106,   5, 64'hA6,         1, 16'h123C, 32'h00000C80};
    tv[6]  = '{64'h0602010005,   5, 64'hA6,         1, 16'h1238, 32'h00000C90};
    tv[7]  = '{64'h0610000016,   5, 64'hE2,         1, 16'h1238, 32'h00000C90};
    tv[8]  = '{64'h047856341200 | 64'h0C, 6, 64'hA4, 1, 16'h1238, 32'h12345678};
    tv[9]  = '{64'h0202,         2, 64'hA278563412, 5, 16'h1238, 32'h12345678};
    tv[10] = '{64'h03FFFF03,     4, 64'hA3,         1, 16'hFFFF, 32'h12345678};
    tv[11] = '{64'h0101,         2, 64'hA1FFFF,     3, 16'hFFFF, 32'h12345678};
    tv[12] = '{64'h0505,         2, 64'hA50A,       2, 16'hFFFF, 32'h12345678};

    // reset state while held in reset
    #2;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'h0);
    chk("rst_selectors", selectors,        32'h0);
    chk("rst_enabled",  32'(enabled_out),  32'h0);
    chk("rst_overrun",  32'(err_overrun),  32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 13; i++) begin
      push_resp(tv[i].rs, tv[i].rn);
      send_frame(tv[i].fr, tv[i].fn);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_enabled", i), 32'(enabled_out), 32'(tv[i].en));
      chk($sformatf("vec%0d_selectors", i), selectors, tv[i].sel);
    end

    // timeout: no response inside the idle window, then NAK E4, then a clean read
    send(8'h04);
    early = 1'b0;
    repeat (TMO) begin
      tick();
      if (bus.tx_valid) early = 1'b1;
    end
    chk("tmo_quiet", 32'(early), 32'h0);
    push_resp(64'hE4, 1);
    drain("tmo_nak");
    chk("tmo_selectors", selectors, 32'h12345678);
    push_resp(64'hA278563412, 5);
    send_frame(64'h0202, 2);
    drain("post_tmo_read");

    // backpressure: status byte held stable, byte during TX flags overrun
    bus.tx_ready = 1'b0;
    push_resp(64'hA50A, 2);
    send_frame(64'h0505, 2);
    tick();
    chk("ovr_before", 32'(err_overrun), 32'h0);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
      end
      tick();
      bus.rx_valid = 1'b0;
      if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'hA5)) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'h1);
    chk("ovr_after", 32'(err_overrun), 32'h1);
    bus.tx_ready = 1'b1;
    drain("held_read_in");
    chk("ovr_sticky", 32'(err_overrun), 32'h1);

    // reset in the middle of a response
    bus.tx_ready = 1'b0;
    send_frame(64'h0101, 2);
    tick();
    chk("pre_rst_valid", 32'(bus.tx_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("mid_rst_selectors", selectors, 32'h0);
    chk("mid_rst_enabled", 32'(enabled_out), 32'h0);
    chk("mid_rst_overrun", 32'(err_overrun), 32'h0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.tx_ready = 1'b1;
    tick();
    push_resp(64'hA10000, 3);
    send_frame(64'h0101, 2);
    drain("post_rst_read");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
